// File: rtl/cpu_step_pkg.sv
// Shared definitions for the CPU step controller: FSM state encoding,
// default timing parameters and a counter-width helper.
package cpu_step_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP   = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } step_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms at 100 MHz
  localparam int unsigned DEF_RUN_DIV         = 50_000_000; // 2 Hz at 100 MHz
  localparam int unsigned DEF_CNT_W           = 16;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces the raw push button, emitting a one-cycle
// registered pulse on each accepted press (releases are silent).
module btn_debounce
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic Reset,
  input  logic Button,
  output logic press
);

  localparam int unsigned     DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_meta;
  logic            sync_lvl;
  logic            stable;
  logic            stable_d;
  logic [DB_W-1:0] db_cnt;

  // NOTE: non-blocking assignments so every flop samples its pre-edge inputs;
  // blocking here would collapse the synchroniser into a single stage.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sync_meta <= 1'b0;
      sync_lvl  <= 1'b0;
      stable    <= 1'b0;
      stable_d  <= 1'b0;
      db_cnt    <= '0;
      press     <= 1'b0;
    end else begin
      sync_meta <= Button;
      sync_lvl  <= sync_meta;
      stable_d  <= stable;
      press     <= stable & ~stable_d;

      // Any glitch back to the stable level restarts the qualification window.
      if (sync_lvl == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= sync_lvl;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable sequencer: single-step on button press, free-run at a
// fixed rate, permanent stop on a decoded halt until Reset.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RUN_DIV         = DEF_RUN_DIV,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Button,
  input  logic             run_mode,
  input  logic             halt,
  output logic             cpu_step,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned       RATE_W    = cnt_width(RUN_DIV);
  localparam logic [RATE_W-1:0] RATE_LAST = RATE_W'(RUN_DIV - 1);

  step_state_e       state_q;
  step_state_e       state_d;
  logic [RATE_W-1:0] rate_cnt;
  logic [RATE_W-1:0] rate_cnt_d;
  logic              step_d;
  logic              press;
  logic              tick;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK   (CLK),
    .Reset (Reset),
    .Button(Button),
    .press (press)
  );

  assign tick = (rate_cnt == RATE_LAST);

  // NOTE: every variable gets a default before the case so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    rate_cnt_d = rate_cnt;
    step_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = HALTED;
        end else if (press) begin
          rate_cnt_d = '0;
          if (run_mode) begin
            state_d = RUN;
          end else begin
            state_d = STEP;
            step_d  = 1'b1;
          end
        end
      end

      STEP: state_d = IDLE;

      // Halt beats a user stop, which beats the rate tick.
      RUN: begin
        rate_cnt_d = tick ? '0 : rate_cnt + 1'b1;
        if (halt) begin
          state_d = HALTED;
        end else if (press || !run_mode) begin
          state_d = IDLE;
        end else if (tick) begin
          step_d = 1'b1;
        end
      end

      HALTED: state_d = HALTED;

      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      rate_cnt   <= '0;
      cpu_step   <= 1'b0;
      halted     <= 1'b0;
      step_count <= '0;
    end else begin
      state_q  <= state_d;
      rate_cnt <= rate_cnt_d;
      cpu_step <= step_d;
      halted   <= (state_d == HALTED);
      if (cpu_step && (step_count != '1)) begin
        step_count <= step_count + 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule
